// File: rtl/rgmii_rx_pkg.sv
// Shared types and constants for the RGMII receive decoder.
// The CRC helpers are only referenced when RGMII_RX_FCS_CHECK_EN is defined.
package rgmii_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  // Normal (MSB-first) polynomial; the byte update uses its bit-reversed form.
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  // Good-frame residue, expressed MSB-first (bit-reverse of the LSB-first register).
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  localparam logic [1:0]  SPEED_10M     = 2'b00;
  localparam logic [1:0]  SPEED_100M    = 2'b01;
  localparam logic [1:0]  SPEED_1G      = 2'b10;

  // Reverse the bit order of a 32-bit word.
  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // One byte of reflected CRC-32: data bits are consumed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic [31:0] poly_refl;
    c         = crc;
    poly_refl = bitrev32(CRC32_POLY);
    for (int i = 0; i < 8; i++) begin
      if ((c[0] ^ data[i]) == 1'b1) begin
        c = (c >> 1) ^ poly_refl;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/ethernet_crc32.sv
// Byte-wide registered Ethernet CRC-32 (reflected, LSB-first register).
// Only built when RGMII_RX_FCS_CHECK_EN is defined; the decoder has no
// CRC logic at all otherwise.
`ifdef RGMII_RX_FCS_CHECK_EN
module ethernet_crc32
  import rgmii_rx_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Next CRC value: restart on clear, fold in one byte on enable.
  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC32_INIT;
    end else if (enable) begin
      crc_d = crc32_byte(crc_q, data);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule
`endif

// File: rtl/rgmii_rx_decoder.sv
// RGMII receive decoder: strips preamble/SFD from the byte stream produced by
// the DDR capture stages, frames the payload, flags bad frames and tracks
// in-band link status. Every payload byte is held one cycle so m_last can be
// asserted on the byte itself, giving a fixed two-cycle latency.
// Optional FCS checking is enabled by defining RGMII_RX_FCS_CHECK_EN.
module rgmii_rx_decoder
  import rgmii_rx_pkg::*;
#(
  parameter int unsigned MIN_FRAME_BYTES = 64,
  parameter int unsigned MAX_FRAME_BYTES = 1522
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic [1:0]  rx_control,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        m_error,
  output logic        link_up,
  output logic [1:0]  link_speed,
  output logic [31:0] frame_count,
  output logic [31:0] error_count
);

  localparam int unsigned LEN_W = $clog2(MAX_FRAME_BYTES + 1);
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME_BYTES);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_BYTES);

  rx_state_e        state_q, state_d;
  logic             hold_valid_q, hold_valid_d;
  logic [7:0]       hold_data_q, hold_data_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             m_error_q, m_error_d;
  logic             link_up_q, link_up_d;
  logic [1:0]       link_speed_q, link_speed_d;
  logic [31:0]      frame_count_q, frame_count_d;
  logic [31:0]      error_count_q, error_count_d;

  logic             rx_dv_s;
  logic             rx_er_s;
  logic [LEN_W-1:0] len_inc_s;
  logic             overflow_s;
  logic             frame_start_s;
  logic             capture_s;
  logic             emit_last_s;
  logic             fcs_bad_s;
  logic             frame_bad_s;

  assign rx_dv_s   = rx_control[0];
  assign rx_er_s   = rx_control[0] ^ rx_control[1];
  assign len_inc_s = len_q + {{(LEN_W-1){1'b0}}, 1'b1};

  // The held byte is the MAX_FRAME_BYTES-th byte of the frame.
  assign overflow_s    = hold_valid_q & (len_inc_s == MAX_LEN);
  assign frame_start_s = rx_dv_s & (rx_data == SFD_BYTE) &
                         ((state_q == ST_IDLE) | (state_q == ST_PREAMBLE));
  // Payload byte accepted into the hold stage (nothing after an overflow).
  assign capture_s     = rx_dv_s & (state_q == ST_PAYLOAD) & ~overflow_s;
  // A held byte is only ever present in PAYLOAD, so if no successor is being
  // captured this cycle the held byte is the last one of the frame.
  assign emit_last_s   = hold_valid_q & ~capture_s;

`ifdef RGMII_RX_FCS_CHECK_EN
  logic [31:0] crc_s;

  ethernet_crc32 u_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (frame_start_s),
    .enable (capture_s),
    .data   (rx_data),
    .crc    (crc_s)
  );

  assign fcs_bad_s = (bitrev32(crc_s) != CRC32_RESIDUE);
`else
  assign fcs_bad_s = 1'b0;
`endif

  assign frame_bad_s = err_q | (len_inc_s < MIN_LEN) | overflow_s | fcs_bad_s;

  // Next-state, hold stage, output and counter computation.
  always_comb begin
    state_d       = state_q;
    hold_valid_d  = 1'b0;
    hold_data_d   = hold_data_q;
    err_d         = err_q;
    len_d         = len_q;
    m_data_d      = m_data_q;
    m_valid_d     = 1'b0;
    m_last_d      = 1'b0;
    m_error_d     = 1'b0;
    link_up_d     = link_up_q;
    link_speed_d  = link_speed_q;
    frame_count_d = frame_count_q;
    error_count_d = error_count_q;

    // Emit the byte held from the previous cycle.
    if (hold_valid_q) begin
      m_valid_d = 1'b1;
      m_data_d  = hold_data_q;
      len_d     = len_inc_s;
      if (emit_last_s) begin
        m_last_d      = 1'b1;
        m_error_d     = frame_bad_s;
        frame_count_d = frame_count_q + 32'd1;
        if (frame_bad_s) begin
          error_count_d = error_count_q + 32'd1;
        end else begin
          error_count_d = error_count_q;
        end
      end else begin
        m_last_d = 1'b0;
      end
    end else begin
      m_valid_d = 1'b0;
    end

    // Load the hold stage, or restart per-frame state on SFD.
    if (frame_start_s) begin
      len_d = {LEN_W{1'b0}};
      err_d = 1'b0;
    end else if (capture_s) begin
      hold_valid_d = 1'b1;
      hold_data_d  = rx_data;
      err_d        = err_q | rx_er_s;
    end else begin
      hold_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_dv_s) begin
          if (rx_data == PREAMBLE_BYTE) begin
            state_d = ST_PREAMBLE;
          end else if (rx_data == SFD_BYTE) begin
            state_d = ST_PAYLOAD;
          end else begin
            state_d = ST_DROP;
          end
        end else if (!rx_er_s) begin
          // Normal inter-frame: rx_data carries in-band link status.
          link_up_d    = rx_data[0];
          link_speed_d = rx_data[2:1];
        end else begin
          // False carrier / carrier extension carries no status.
          state_d = ST_IDLE;
        end
      end
      ST_PREAMBLE: begin
        if (!rx_dv_s) begin
          state_d = ST_IDLE;
        end else if (rx_data == SFD_BYTE) begin
          state_d = ST_PAYLOAD;
        end else if (rx_data == PREAMBLE_BYTE) begin
          state_d = ST_PREAMBLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_PAYLOAD: begin
        if (!rx_dv_s) begin
          state_d = ST_IDLE;
        end else if (overflow_s) begin
          state_d = ST_DROP;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_DROP: begin
        if (!rx_dv_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All decoder state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      hold_valid_q  <= 1'b0;
      hold_data_q   <= 8'h00;
      err_q         <= 1'b0;
      len_q         <= {LEN_W{1'b0}};
      m_data_q      <= 8'h00;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      m_error_q     <= 1'b0;
      link_up_q     <= 1'b0;
      link_speed_q  <= SPEED_10M;
      frame_count_q <= 32'd0;
      error_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      hold_valid_q  <= hold_valid_d;
      hold_data_q   <= hold_data_d;
      err_q         <= err_d;
      len_q         <= len_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      m_error_q     <= m_error_d;
      link_up_q     <= link_up_d;
      link_speed_q  <= link_speed_d;
      frame_count_q <= frame_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign m_error     = m_error_q;
  assign link_up     = link_up_q;
  assign link_speed  = link_speed_q;
  assign frame_count = frame_count_q;
  assign error_count = error_count_q;

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// Randomized bench for rgmii_rx_decoder. Frames are described at the frame
// level (preamble length, payload, error position, FCS) and the expected
// output byte stream, frame verdict and counters are derived from that
// description; a negedge monitor compares the DUT stream against it.
module tb_rgmii_rx_decoder;

  localparam int MIN_B = 64;
  localparam int MAX_B = 1522;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data;
  logic [1:0]  rx_control;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_error;
  logic        link_up;
  logic [1:0]  link_speed;
  logic [31:0] frame_count;
  logic [31:0] error_count;

  rgmii_rx_decoder #(.MIN_FRAME_BYTES(MIN_B), .MAX_FRAME_BYTES(MAX_B)) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_control  (rx_control),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_error     (m_error),
    .link_up     (link_up),
    .link_speed  (link_speed),
    .frame_count (frame_count),
    .error_count (error_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       e;
    int         c;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         mon_en = 1'b1;
  int         exp_frames = 0;
  int         exp_errors = 0;
  logic [7:0] link_val = 8'h05;

  // Cycle counter used to time-stamp expected outputs.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output stream monitor.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_byte", m_valid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("data", m_data, mon_e.d);
          check_eq("last", m_last, mon_e.l);
          check_eq("error", m_error, mon_e.e);
          check_eq("latency", cyc, mon_e.c);
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].c) begin
        check_eq("missing_byte", m_valid, 1'b1);
        void'(exp_q.pop_front());
      end
      if (m_error) check_eq("error_without_last", m_last, 1'b1);
    end
  end

  task automatic drive(input logic [7:0] d, input logic [1:0] ctl);
    @(posedge clock);
    #1;
    rx_data    = d;
    rx_control = ctl;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(link_val, 2'b00);
  endtask

  // Standard Ethernet CRC over the first cnt bytes; returns the FCS value.
  function automatic logic [31:0] ref_fcs(input logic [7:0] b[], input int cnt);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < cnt; i++) begin
      for (int k = 0; k < 8; k++) begin
        if ((c[0] ^ b[i][k]) == 1'b1) c = (c >> 1) ^ 32'hEDB88320;
        else c = c >> 1;
      end
    end
    return ~c;
  endfunction

  // A frame is FCS-good when its trailing four bytes equal the CRC of the rest.
  function automatic bit fcs_ok(input logic [7:0] b[], input int n);
    logic [31:0] f;
    if (n < 5) return 1'b0;
    f = ref_fcs(b, n - 4);
    return {b[n-1], b[n-2], b[n-3], b[n-4]} == f;
  endfunction

  // Send one frame and record what the decoder must emit for it.
  task automatic send_frame(input int plen, input int len, input int er_pos,
                            input bit with_fcs, input int flip_bit);
    logic [7:0] pl[];
    logic [31:0] f;
    int n;
    bit bad;
    pl = new[len];
    for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
    if (with_fcs && len >= 8) begin
      f = ref_fcs(pl, len - 4);
      pl[len-4] = f[7:0];
      pl[len-3] = f[15:8];
      pl[len-2] = f[23:16];
      pl[len-1] = f[31:24];
    end
    if (flip_bit >= 0) pl[len-1][flip_bit % 8] = ~pl[len-1][flip_bit % 8];

    n   = (len >= MAX_B) ? MAX_B : len;
    bad = (n < MIN_B) || (len >= MAX_B) || (er_pos >= 0 && er_pos < n);
`ifdef RGMII_RX_FCS_CHECK_EN
    if (!fcs_ok(pl, n)) bad = 1'b1;
`endif
    if (n > 0) begin
      exp_frames++;
      if (bad) exp_errors++;
    end

    for (int p = 0; p < plen; p++) drive(8'h55, 2'b11);
    drive(8'hD5, 2'b11);
    for (int i = 0; i < len; i++) begin
      drive(pl[i], (i == er_pos) ? 2'b01 : 2'b11);
      if (i < n) exp_q.push_back('{pl[i], (i == n - 1), (i == n - 1) && bad, cyc + 2});
    end
  endtask

  task automatic check_counters(input string tag);
    check_eq({tag, "_frame_count"}, frame_count, 64'(exp_frames));
    check_eq({tag, "_error_count"}, error_count, 64'(exp_errors));
  endtask

  initial begin
    rx_data    = link_val;
    rx_control = 2'b00;
    reset      = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_m_data", m_data, 8'h00);
    check_eq("rst_m_valid", m_valid, 1'b0);
    check_eq("rst_m_last", m_last, 1'b0);
    check_eq("rst_m_error", m_error, 1'b0);
    check_eq("rst_link_up", link_up, 1'b0);
    check_eq("rst_link_speed", link_speed, 2'b00);
    check_counters("rst");
    reset = 1'b0;

    // In-band status 0x05: link up at 1G.
    idle(4);
    check_eq("link_up_05", link_up, 1'b1);
    check_eq("link_speed_05", link_speed, 2'b10);
    // False carrier must not disturb status.
    drive(8'h00, 2'b10);
    drive(8'h00, 2'b10);
    check_eq("fc_link_up", link_up, 1'b1);
    check_eq("fc_link_speed", link_speed, 2'b10);
    idle(2);

    // Good 64-byte frame.
    send_frame(7, 64, -1, 1'b1, -1);
    idle(3);
    check_counters("good64");
    // rx_er on byte 10.
    send_frame(7, 64, 10, 1'b1, -1);
    idle(3);
    check_counters("er64");
    // Runt.
    send_frame(7, 40, -1, 1'b1, -1);
    idle(2);
    // One-byte frame with no preamble.
    send_frame(0, 1, -1, 1'b0, -1);
    idle(2);
    // Corrupted FCS.
    send_frame(7, 64, -1, 1'b1, 3);
    idle(2);
    // Bad preamble: whole burst dropped.
    drive(8'h55, 2'b11);
    drive(8'h12, 2'b11);
    for (int i = 0; i < 10; i++) drive(8'($urandom), 2'b11);
    idle(3);
    check_counters("misc");

    // Oversize frame, then a back-to-back frame after a single idle cycle.
    send_frame(7, 1600, -1, 1'b1, -1);
    idle(1);
    send_frame(3, 80, -1, 1'b1, -1);
    idle(3);
    check_counters("oversize");

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      send_frame(int'($urandom_range(0, 7)),
                 ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 70)) : int'($urandom_range(60, 200)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 80)) : -1,
                 1'b1,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
      idle(int'($urandom_range(1, 3)));
    end
    idle(3);
    check_counters("random");

    // Status change: link up at 100M, then link down.
    link_val = 8'h03;
    idle(3);
    check_eq("link_up_03", link_up, 1'b1);
    check_eq("link_speed_03", link_speed, 2'b01);
    link_val = 8'h00;
    idle(3);
    check_eq("link_up_00", link_up, 1'b0);
    link_val = 8'h05;
    idle(2);

    // Reset in the middle of a frame.
    mon_en = 1'b0;
    for (int p = 0; p < 7; p++) drive(8'h55, 2'b11);
    drive(8'hD5, 2'b11);
    for (int i = 0; i < 30; i++) drive(8'($urandom), 2'b11);
    #3;
    reset = 1'b1;
    #1;
    check_eq("midrst_m_valid", m_valid, 1'b0);
    check_eq("midrst_m_last", m_last, 1'b0);
    exp_q.delete();
    exp_frames = 0;
    exp_errors = 0;
    check_counters("midrst");
    rx_data    = link_val;
    rx_control = 2'b00;
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(3);
    mon_en = 1'b1;
    send_frame(7, 70, -1, 1'b1, -1);
    idle(4);
    check_counters("after_rst");
    check_eq("drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
